mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port word-addressed RAM between the instruction-fetch (IF) and data-memory (DM) requesters.
//  Performs one access per grant and returns a registered response to the winning requester.
//  DM normally has priority; a streak limit keeps IF from starving.
//  Sits between pipeline fetch/mem stages and the RAM instance (comb read, posedge write).
// PARAMETERS
//  ADDR_W        10  word address width (1024-word RAM)
//  DATA_W        32  data word width
//  MAX_DM_STREAK 4   max consecutive DM grants while IF waits; range 1..15
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst            in   1       asynchronous, active-high reset
//  if_req         in   1       IF read request; held with if_addr stable until if_ready
//  if_addr        in   ADDR_W  IF word address
//  if_ready       out  1       IF request accepted this cycle
//  if_resp_valid  out  1       1-cycle pulse, if_rdata valid
//  if_rdata       out  DATA_W  fetched word
//  dm_req         in   1       DM request; held with we/addr/wdata stable until dm_ready
//  dm_we          in   1       1 = store, 0 = load
//  dm_addr        in   ADDR_W  DM word address
//  dm_wdata       in   DATA_W  store data
//  dm_ready       out  1       DM request accepted this cycle
//  dm_resp_valid  out  1       1-cycle pulse: load data valid or store done
//  dm_rdata       out  DATA_W  load data; 0 for stores
//  ram_write_enable out 1      to RAM write_enable
//  ram_read_enable  out 1      to RAM read_enable
//  ram_addr       out  ADDR_W  to RAM addr
//  ram_write_data out  DATA_W  to RAM write_data
//  ram_read_data  in   DATA_W  from RAM read_data (combinational)
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  FSM states: IDLE, ACCESS, RESP. Only IDLE and RESP can accept a request.
//  Accept (IDLE/RESP, some req high): grant per priority; ready is combinational for exactly the winner.
//   Latch owner, we, addr, wdata into registers. Next state ACCESS.
//  IDLE/RESP with no req: next state IDLE.
//  ACCESS, cycle N+1: drive RAM from registers, with read_enable = !we and write_enable = we.
//   Capture ram_read_data (0 if write) at posedge. Next state RESP.
//  RESP, cycle N+2: owner's resp_valid = 1 and rdata = captured word. Back-to-back accept is allowed.
//  Latency: accept N -> resp_valid N+2. Max throughput is 1 access per 2 cycles.
//  Outside ACCESS, all ram_* outputs are 0. RAM is never enabled in IDLE/RESP.
//  Non-owner resp_valid = 0. rdata holds its last value until the next response.
//  Priority:
//   DM wins if dm_req and !(if_req && streak == MAX_DM_STREAK). Otherwise IF wins if if_req.
//  streak (4-bit) update on each grant:
//   DM grant with if_req high -> streak+1.
//   IF grant -> 0. DM grant with if_req low -> 0.
//  Both requests in the same cycle: exactly one ready. The loser keeps req high and is not dropped.
//  Requester dropping req before ready: legal, nothing latched.
//  Store-then-load to the same address: the load returns the stored word (write committed in the earlier ACCESS).
//  Reset (async, any state): state = IDLE and streak = 0. All outputs 0, including rdata, ram_* and busy.
//   An in-flight access is abandoned with no resp_valid. The RAM drops writes during rst anyway.
// TESTING
//  1. IF only: if_req, if_addr=5, RAM[5]=0xDEADBEEF -> if_ready@N, ram_read_enable@N+1, if_resp_valid@N+2 with if_rdata=0xDEADBEEF.
//  2. DM store then load: store addr=50 data=100, then load addr=50 -> dm_rdata=100 on the second response; the store response has dm_rdata=0.
//  3. Both req continuously, MAX_DM_STREAK=4 -> grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF; no lost request.
//  4. Back-to-back: dm_req held for 3 loads -> accepts at cycles 0, 2, 4 and responses at 2, 4, 6; busy stays high throughout.
//  5. Reset asserted in ACCESS of a store to addr=7 -> all outputs 0 immediately, no dm_resp_valid, RAM[7] unchanged, FSM in IDLE after release.
//  6. Request withdrawn: if_req high in a cycle where DM wins, then if_req low -> no IF access, no if_resp_valid.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-side signals of the IF/DM memory port arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic              if_resp_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ready;
   logic              dm_resp_valid;
   logic [DATA_W-1:0] dm_rdata;

   logic              ram_write_enable;
   logic              ram_read_enable;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_write_data;
   logic [DATA_W-1:0] ram_read_data;

   logic              busy;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_read_data,
      output if_ready, if_resp_valid, if_rdata,
      output dm_ready, dm_resp_valid, dm_rdata,
      output ram_write_enable, ram_read_enable, ram_addr, ram_write_data,
      output busy
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_read_data,
      input  if_ready, if_resp_valid, if_rdata,
      input  dm_ready, dm_resp_valid, dm_rdata,
      input  ram_write_enable, ram_read_enable, ram_addr, ram_write_data,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and data memory.
// Accept at N, RAM access at N+1, response at N+2; DM has priority bounded by a streak limit.
module mem_port_arbiter #(
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 32,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q;
   logic              owner_dm_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic [3:0]        streak_q;
   logic [3:0]        streak_d;

   logic can_accept;
   logic streak_full;
   logic dm_win;
   logic if_win;
   logic in_access;
   logic in_resp;

   // Ready is gated by rst so every output is 0 while reset is held.
   always_comb begin
      can_accept  = !rst && (state_q == IDLE || state_q == RESP);
      streak_full = bus.if_req && (streak_q == 4'(MAX_DM_STREAK));
      dm_win      = can_accept && bus.dm_req && !streak_full;
      if_win      = can_accept && bus.if_req && !dm_win;
      streak_d    = (dm_win && bus.if_req) ? streak_q + 4'd1 : 4'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_dm_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         streak_q   <= 4'd0;
      end else begin
         case (state_q)
            ACCESS: begin
               if (owner_dm_q) begin
                  dm_rdata_q <= we_q ? '0 : bus.ram_read_data;
               end else begin
                  if_rdata_q <= bus.ram_read_data;
               end
               state_q <= RESP;
            end
            default: begin
               if (dm_win || if_win) begin
                  owner_dm_q <= dm_win;
                  we_q       <= dm_win && bus.dm_we;
                  addr_q     <= dm_win ? bus.dm_addr : bus.if_addr;
                  wdata_q    <= dm_win ? bus.dm_wdata : '0;
                  streak_q   <= streak_d;
                  state_q    <= ACCESS;
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign in_access = (state_q == ACCESS);
   assign in_resp   = (state_q == RESP);

   assign bus.if_ready      = if_win;
   assign bus.dm_ready      = dm_win;
   assign bus.if_resp_valid = in_resp && !owner_dm_q;
   assign bus.dm_resp_valid = in_resp && owner_dm_q;
   assign bus.if_rdata      = if_rdata_q;
   assign bus.dm_rdata      = dm_rdata_q;

   // The RAM only sees the latched access, and only during ACCESS.
   assign bus.ram_read_enable  = in_access && !we_q;
   assign bus.ram_write_enable = in_access && we_q;
   assign bus.ram_addr         = in_access ? addr_q  : '0;
   assign bus.ram_write_data   = in_access ? wdata_q : '0;

   assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a transaction-level model.
module tb_mem_port_arbiter;
   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int MAXS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM: combinational read, posedge write, writes dropped during reset
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign bus.ram_read_data = mem[bus.ram_addr];
   always @(posedge clk) if (!rst && bus.ram_write_enable) mem[bus.ram_addr] <= bus.ram_write_data;

   int pass_cnt = 0;
   int total    = 0;
   int cyc      = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   // Transaction-level model: an accepted request occupies the RAM the cycle after
   // acceptance and answers the cycle after that.
   typedef struct packed {
      logic          v;
      logic          dm;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } txn_t;

   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   txn_t          a1, a2;
   int            streak;
   logic [DW-1:0] e_if_rd, e_dm_rd;

   string         grant_log;
   int            if_acc_cyc[$], dm_acc_cyc[$], if_resp_cyc[$], dm_resp_cyc[$], re_cyc[$], busy_lo_cyc[$];
   logic [DW-1:0] dm_resp_dat[$];

   always @(negedge clk) begin
      txn_t g;
      logic can, dmw, ifw;
      cyc++;
      if (rst) begin
         chk("rst_ready",  {bus.if_ready, bus.dm_ready}, 0);
         chk("rst_resp",   {bus.if_resp_valid, bus.dm_resp_valid}, 0);
         chk("rst_rdata",  {bus.if_rdata, bus.dm_rdata}, 0);
         chk("rst_ram",    {bus.ram_write_enable, bus.ram_read_enable, bus.ram_addr}, 0);
         chk("rst_ram_wd", bus.ram_write_data, 0);
         chk("rst_busy",   bus.busy, 0);
         a1 = '0; a2 = '0; streak = 0; e_if_rd = '0; e_dm_rd = '0;
      end else begin
         if (a1.v) begin
            if (a1.we) begin
               ref_mem[a1.addr] = a1.wdata;
               a1.rdata = '0;
            end else begin
               a1.rdata = ref_mem[a1.addr];
            end
         end
         chk("ram_we",    bus.ram_write_enable, a1.v && a1.we);
         chk("ram_re",    bus.ram_read_enable,  a1.v && !a1.we);
         chk("ram_addr",  bus.ram_addr,       a1.v ? a1.addr  : '0);
         chk("ram_wdata", bus.ram_write_data, a1.v ? a1.wdata : '0);

         if (a2.v && a2.dm)  e_dm_rd = a2.rdata;
         if (a2.v && !a2.dm) e_if_rd = a2.rdata;
         chk("if_resp_valid", bus.if_resp_valid, a2.v && !a2.dm);
         chk("dm_resp_valid", bus.dm_resp_valid, a2.v && a2.dm);
         chk("if_rdata", bus.if_rdata, e_if_rd);
         chk("dm_rdata", bus.dm_rdata, e_dm_rd);
         chk("busy", bus.busy, a1.v || a2.v);

         can = !a1.v;
         dmw = can && bus.dm_req && !(bus.if_req && streak == MAXS);
         ifw = can && bus.if_req && !dmw;
         chk("dm_ready", bus.dm_ready, dmw);
         chk("if_ready", bus.if_ready, ifw);
         if (dmw) streak = bus.if_req ? streak + 1 : 0;
         if (ifw) streak = 0;

         g       = '0;
         g.v     = dmw || ifw;
         g.dm    = dmw;
         g.we    = dmw && bus.dm_we;
         g.addr  = dmw ? bus.dm_addr : bus.if_addr;
         g.wdata = dmw ? bus.dm_wdata : '0;
         a2 = a1;
         a1 = g;
      end
      if (bus.dm_ready)        begin grant_log = {grant_log, "D"}; dm_acc_cyc.push_back(cyc); end
      if (bus.if_ready)        begin grant_log = {grant_log, "I"}; if_acc_cyc.push_back(cyc); end
      if (bus.dm_resp_valid)   begin dm_resp_cyc.push_back(cyc); dm_resp_dat.push_back(bus.dm_rdata); end
      if (bus.if_resp_valid)   if_resp_cyc.push_back(cyc);
      if (bus.ram_read_enable) re_cyc.push_back(cyc);
      if (!bus.busy && !rst)   busy_lo_cyc.push_back(cyc);
   end

   task automatic clear_logs();
      grant_log = "";
      if_acc_cyc.delete(); dm_acc_cyc.delete(); if_resp_cyc.delete(); dm_resp_cyc.delete();
      re_cyc.delete(); busy_lo_cyc.delete(); dm_resp_dat.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.if_req = 0; bus.if_addr = '0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_logs();
   endtask

   task automatic next_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic dm_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic got = 0;
      bus.dm_req = 1; bus.dm_we = we; bus.dm_addr = a; bus.dm_wdata = d;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = bus.dm_ready;
      end
      chk("dm_handshake", got, 1);
      next_cyc(1);
      bus.dm_req = 0;
   endtask

   task automatic if_op(input logic [AW-1:0] a);
      logic got = 0;
      bus.if_req = 1; bus.if_addr = a;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = bus.if_ready;
      end
      chk("if_handshake", got, 1);
      next_cyc(1);
      bus.if_req = 0;
   endtask

   initial begin
      int n, bad, a0;
      logic ia, da;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      do_reset();

      // 1: IF only read of address 5
      mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
      do_reset();
      if_op(10'd5);
      next_cyc(4);
      a0 = q_at(if_acc_cyc, 0);
      chk("t1_acc_count", if_acc_cyc.size(), 1);
      chk("t1_re_cycle",   q_at(re_cyc, 0), a0 + 1);
      chk("t1_resp_cycle", q_at(if_resp_cyc, 0), a0 + 2);
      chk("t1_rdata", bus.if_rdata, 32'hDEADBEEF);

      // 2: store then load of address 50
      do_reset();
      dm_op(1'b1, 10'd50, 32'd100);
      dm_op(1'b0, 10'd50, 32'd0);
      next_cyc(4);
      chk("t2_resp_count", dm_resp_dat.size(), 2);
      if (dm_resp_dat.size() == 2) begin
         chk("t2_store_rdata", dm_resp_dat[0], 0);
         chk("t2_load_rdata",  dm_resp_dat[1], 100);
      end

      // 3: both requesters always asking
      do_reset();
      bus.if_req = 1; bus.if_addr = 10'd3;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'd4;
      for (int i = 0; i < 60 && grant_log.len() < 10; i++) @(negedge clk);
      next_cyc(1);
      bus.if_req = 0; bus.dm_req = 0;
      next_cyc(3);
      if (grant_log != "DDDDIDDDDI") $display("FAIL t3_grant_order actual=%s required=DDDDIDDDDI", grant_log);
      chk("t3_grant_order_ok", grant_log == "DDDDIDDDDI", 1);

      // 4: three back-to-back loads
      do_reset();
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'd9;
      n = 0;
      for (int i = 0; i < 40 && n < 3; i++) begin
         @(negedge clk);
         if (bus.dm_ready) n++;
      end
      next_cyc(1);
      bus.dm_req = 0;
      next_cyc(4);
      a0 = q_at(dm_acc_cyc, 0);
      chk("t4_acc1",  q_at(dm_acc_cyc, 1) - a0, 2);
      chk("t4_acc2",  q_at(dm_acc_cyc, 2) - a0, 4);
      chk("t4_resp0", q_at(dm_resp_cyc, 0) - a0, 2);
      chk("t4_resp1", q_at(dm_resp_cyc, 1) - a0, 4);
      chk("t4_resp2", q_at(dm_resp_cyc, 2) - a0, 6);
      bad = 0;
      foreach (busy_lo_cyc[i]) if (busy_lo_cyc[i] > a0 && busy_lo_cyc[i] <= a0 + 6) bad++;
      chk("t4_busy_gaps", bad, 0);

      // 5: reset during the ACCESS of a store
      mem[7] = 32'h12345678; ref_mem[7] = 32'h12345678;
      do_reset();
      dm_op(1'b1, 10'd7, 32'h0000AAAA);
      rst = 1'b1;
      #1;
      chk("t5_ram_we_in_rst", bus.ram_write_enable, 0);
      chk("t5_busy_in_rst", bus.busy, 0);
      next_cyc(2);
      rst = 1'b0;
      next_cyc(3);
      chk("t5_mem7", mem[7], 32'h12345678);
      chk("t5_no_resp", dm_resp_cyc.size(), 0);
      chk("t5_idle", bus.busy, 0);

      // 6: IF withdraws after losing to DM
      do_reset();
      bus.if_req = 1; bus.if_addr = 10'd3;
      dm_op(1'b1, 10'd20, 32'd55);
      bus.if_req = 0;
      next_cyc(5);
      chk("t6_no_if_acc",  if_acc_cyc.size(), 0);
      chk("t6_no_if_resp", if_resp_cyc.size(), 0);
      chk("t6_dm_resp",    dm_resp_cyc.size(), 1);

      // Random traffic with occasional resets and withdrawals
      do_reset();
      repeat (1500) begin
         @(negedge clk);
         ia = bus.if_ready; da = bus.dm_ready;
         next_cyc(1);
         rst = ($urandom_range(0, 149) == 0);
         if (!bus.if_req || ia) begin
            bus.if_req  = ($urandom_range(0, 3) != 0);
            bus.if_addr = 10'($urandom_range(0, 15));
         end else if ($urandom_range(0, 15) == 0) begin
            bus.if_req = 0;
         end
         if (!bus.dm_req || da) begin
            bus.dm_req   = ($urandom_range(0, 3) != 0);
            bus.dm_we    = $urandom_range(0, 1);
            bus.dm_addr  = 10'($urandom_range(0, 15));
            bus.dm_wdata = $urandom;
         end else if ($urandom_range(0, 15) == 0) begin
            bus.dm_req = 0;
         end
      end
      rst = 1'b0;
      bus.if_req = 0; bus.dm_req = 0;
      next_cyc(4);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
